// File: rtl/otter_pkg.sv
// Shared types for the OTTER load/store unit: access size, FSM states and
// small address helpers used by the LSU and its alignment datapath.
package otter_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Both 2'b10 and 2'b11 encode a word access.
  function automatic lsu_size_e decode_size(input logic [1:0] raw);
    if (raw[1]) return LSU_WORD;
    return raw[0] ? LSU_HALF : LSU_BYTE;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
    case (size)
      LSU_HALF: return lo[0];
      LSU_WORD: return |lo;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] force_align(input lsu_size_e size, input logic [1:0] lo);
    case (size)
      LSU_HALF: return {lo[1], 1'b0};
      LSU_WORD: return 2'b00;
      default:  return lo;
    endcase
  endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// Request/response channel between a core and the OTTER load/store unit.
interface otter_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane datapath: store lane masks and data replication, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_align
  import otter_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rdata_raw[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    byte_en   = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata_raw;
    case (size)
      LSU_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      end
      LSU_HALF: begin
        byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: single-outstanding FSM in front of a synchronous RAM.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
//
//   state | meaning
//   IDLE  | ready for a request, latches it on req_valid
//   ISSUE | drives the RAM strobe / byte write enables for one cycle
//   WAIT  | load data arrives from RAM, extracted into resp_rdata
//   RESP  | one-cycle resp_valid pulse
module otter_lsu
  import otter_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int RAM_BUS_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  otter_lsu_if.slave                lsu,
  output logic                      mem_rd,
  output logic [3:0]                mem_we,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  output logic [RAM_BUS_WIDTH-1:0]  mem_data,
  input  logic [RAM_BUS_WIDTH-1:0]  mem_out
);

  lsu_state_e                state_q, state_d;
  logic                      we_q, uns_q, err_q;
  lsu_size_e                 size_q, req_size_dec;
  logic [RAM_ADDR_WIDTH+1:0] addr_q;
  logic [31:0]               wdata_q, rdata_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_hold_q;
  logic [31:0]               data_hold_q;
  logic                      req_err, issue;
  logic [1:0]                req_lo_al;
  logic [3:0]                byte_en;
  logic [31:0]               wdata_rep, rdata_ext;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^lsu.req_addr[31:RAM_ADDR_WIDTH+2];
  assign req_size_dec   = decode_size(lsu.req_size);

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    req_err   = is_misaligned(req_size_dec, lsu.req_addr[1:0]);
    req_lo_al = lsu.req_addr[1:0];
`else
    req_err   = 1'b0;
    req_lo_al = force_align(req_size_dec, lsu.req_addr[1:0]);
`endif
  end

  lsu_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_raw   (mem_out),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lsu.req_valid) state_d = req_err ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the strobes combinationally so an in-flight store never lands.
  assign issue          = (state_q == ISSUE) && !rst;
  assign mem_rd         = !(issue && !we_q);
  assign mem_we         = (issue && we_q) ? byte_en : 4'b0000;
  assign mem_addr       = rst ? '0 : (issue ? addr_q[RAM_ADDR_WIDTH+1:2] : addr_hold_q);
  assign mem_data       = rst ? '0 : ((issue && we_q) ? wdata_rep : data_hold_q);
  assign lsu.req_ready  = (state_q == IDLE);
  assign lsu.resp_valid = (state_q == RESP) && !rst;
  assign lsu.resp_err   = (state_q == RESP) && !rst && err_q;
  assign lsu.resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= LSU_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (lsu.req_valid) begin
          we_q    <= lsu.req_we;
          uns_q   <= lsu.req_unsigned;
          err_q   <= req_err;
          size_q  <= req_size_dec;
          addr_q  <= {lsu.req_addr[RAM_ADDR_WIDTH+1:2], req_lo_al};
          wdata_q <= lsu.req_wdata;
          if (req_err) rdata_q <= '0;
        end
        ISSUE: begin
          addr_hold_q <= addr_q[RAM_ADDR_WIDTH+1:2];
          if (we_q) begin
            data_hold_q <= wdata_rep;
            rdata_q     <= '0;
          end
        end
        WAIT:    rdata_q <= rdata_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a small synchronous RAM model.
module tb_otter_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd;
  logic [3:0]  mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_out;
  logic [31:0] ram [0:8191];
  int          n_chk = 0;
  int          n_pass = 0;

  otter_lsu_if bus ();

  otter_lsu #(.RAM_ADDR_WIDTH(13), .RAM_BUS_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .lsu      (bus),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
    if (!mem_rd) mem_out <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request in cycle A and checks every cycle up to the next IDLE.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [3:0] exp_we,
                        input logic [31:0] exp_maddr, input logic [31:0] exp_mdata,
                        input logic [31:0] exp_rdata);
    chk({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    step();
    bus.req_valid = 1'b0;
    if (exp_err) begin
      chk({tag, ".err_valid"}, {31'b0, bus.resp_valid}, 32'd1);
      chk({tag, ".err_flag"},  {31'b0, bus.resp_err},   32'd1);
      chk({tag, ".err_rdata"}, bus.resp_rdata,          32'd0);
      chk({tag, ".err_rd"},    {31'b0, mem_rd},         32'd1);
      chk({tag, ".err_we"},    {28'b0, mem_we},         32'd0);
    end else begin
      chk({tag, ".iss_rd"},    {31'b0, mem_rd},         {31'b0, we});
      chk({tag, ".iss_we"},    {28'b0, mem_we},         {28'b0, exp_we});
      chk({tag, ".iss_addr"},  {19'b0, mem_addr},       exp_maddr);
      if (we) chk({tag, ".iss_data"}, mem_data, exp_mdata);
      chk({tag, ".iss_valid"}, {31'b0, bus.resp_valid}, 32'd0);
      step();
      if (!we) begin
        chk({tag, ".wait_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({tag, ".wait_rd"},    {31'b0, mem_rd},         32'd1);
        step();
      end
      chk({tag, ".resp_valid"}, {31'b0, bus.resp_valid}, 32'd1);
      chk({tag, ".resp_err"},   {31'b0, bus.resp_err},   32'd0);
      chk({tag, ".resp_rdata"}, bus.resp_rdata,          exp_rdata);
    end
    step();
    chk({tag, ".done_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'b0, bus.req_ready},  32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) step();
    chk("rst.valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.rd",    {31'b0, mem_rd},         32'd1);
    chk("rst.we",    {28'b0, mem_we},         32'd0);
    rst = 1'b0;
    step();
    chk("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst.rdata", bus.resp_rdata,         32'd0);
    chk("rst.err",   {31'b0, bus.resp_err},  32'd0);
    chk("rst.addr",  {19'b0, mem_addr},      32'd0);
    chk("rst.data",  mem_data,               32'd0);

    run_op("st_w10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'd4, 32'hDEADBEEF, 32'h0);
    run_op("ld_w10",  0, 2'b10, 0, 32'h10, 32'h0,        0, 4'b0000, 32'd4, 32'h0, 32'hDEADBEEF);
    run_op("st_b13",  1, 2'b00, 0, 32'h13, 32'h0000005A, 0, 4'b1000, 32'd4, 32'h5A5A5A5A, 32'h0);
    run_op("ld_b13",  0, 2'b00, 0, 32'h13, 32'h0,        0, 4'b0000, 32'd4, 32'h0, 32'h0000005A);
    run_op("ld_hu10", 0, 2'b01, 1, 32'h10, 32'h0,        0, 4'b0000, 32'd4, 32'h0, 32'h0000BEEF);
    run_op("ld_hs10", 0, 2'b01, 0, 32'h10, 32'h0,        0, 4'b0000, 32'd4, 32'h0, 32'hFFFFBEEF);
    run_op("st_w20",  1, 2'b11, 0, 32'h20, 32'h8000FF80, 0, 4'b1111, 32'd8, 32'h8000FF80, 32'h0);
    run_op("ld_hs22", 0, 2'b01, 0, 32'h22, 32'h0,        0, 4'b0000, 32'd8, 32'h0, 32'hFFFF8000);
    run_op("ld_bu20", 0, 2'b00, 1, 32'h20, 32'h0,        0, 4'b0000, 32'd8, 32'h0, 32'h00000080);
    run_op("ld_bs20", 0, 2'b00, 0, 32'h20, 32'h0,        0, 4'b0000, 32'd8, 32'h0, 32'hFFFFFF80);
    run_op("ld_bs21", 0, 2'b00, 0, 32'h21, 32'h0,        0, 4'b0000, 32'd8, 32'h0, 32'hFFFFFFFF);
    run_op("st_h26",  1, 2'b01, 0, 32'h26, 32'h00001234, 0, 4'b1100, 32'd9, 32'h12341234, 32'h0);
    run_op("ld_hu26", 0, 2'b01, 1, 32'h26, 32'h0,        0, 4'b0000, 32'd9, 32'h0, 32'h00001234);
    run_op("ld_bs27", 0, 2'b00, 0, 32'h27, 32'h0,        0, 4'b0000, 32'd9, 32'h0, 32'h00000012);
    run_op("ld_wrap", 0, 2'b10, 0, 32'h8010, 32'h0,      0, 4'b0000, 32'd4, 32'h0, 32'h5AADBEEF);
    run_op("st_w04",  1, 2'b10, 0, 32'h04, 32'hCAFEF00D, 0, 4'b1111, 32'd1, 32'hCAFEF00D, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op("ld_w06",  0, 2'b10, 0, 32'h06, 32'h0,        1, 4'b0000, 32'd0, 32'h0, 32'h0);
    run_op("ld_h07",  0, 2'b01, 0, 32'h07, 32'h0,        1, 4'b0000, 32'd0, 32'h0, 32'h0);
`else
    run_op("ld_w06",  0, 2'b10, 0, 32'h06, 32'h0,        0, 4'b0000, 32'd1, 32'h0, 32'hCAFEF00D);
    run_op("ld_h07",  0, 2'b01, 0, 32'h07, 32'h0,        0, 4'b0000, 32'd1, 32'h0, 32'hFFFFCAFE);
`endif

    // Reset while a store is in ISSUE: the write must be suppressed immediately.
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h11111111;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("rstiss.pre_we", {28'b0, mem_we}, 32'h0000000F);
    rst = 1'b1;
    #1;
    chk("rstiss.we",   {28'b0, mem_we},    32'd0);
    chk("rstiss.rd",   {31'b0, mem_rd},    32'd1);
    chk("rstiss.addr", {19'b0, mem_addr},  32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rstiss.valid0", {31'b0, bus.resp_valid}, 32'd0);
    chk("rstiss.ready",  {31'b0, bus.req_ready},  32'd1);
    step();
    chk("rstiss.valid1", {31'b0, bus.resp_valid}, 32'd0);
    run_op("ld_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'b0000, 32'd4, 32'h0, 32'h5AADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
